// File: rtl/gaussian_batch_scheduler.sv
// Batch sequencer for the masked multi-sigma Gaussian sampler.
// Accepts one batch request, forces a DRBG reseed when one is pending or the
// sample budget is spent, issues one sampler start per sample and buffers
// each share pair behind a valid/ready output port.
//
// Handshakes: a request transfers on a cycle where req_valid && req_ready;
// an output pair transfers on a cycle where out_valid && out_ready. Once
// out_valid is raised, out_share0/1 and out_last hold until that transfer
// (or an abort/timeout/reset drops the pair).
module gaussian_batch_scheduler #(
  parameter int SAMPLE_WIDTH    = 16,
  parameter int CENTER_WIDTH    = 32,
  parameter int SIGMA_SEL_WIDTH = 2,
  parameter int COUNT_WIDTH     = 16,
  parameter int RESEED_INTERVAL = 1024,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [COUNT_WIDTH-1:0]     req_count,
  input  logic [CENTER_WIDTH-1:0]    req_center,
  input  logic [SIGMA_SEL_WIDTH-1:0] req_sigma_sel,
  input  logic                       abort,
  output logic                       start_reseed,
  input  logic                       reseeding,
  output logic                       start_sample,
  output logic [CENTER_WIDTH-1:0]    center,
  output logic [SIGMA_SEL_WIDTH-1:0] sigma_sel,
  input  logic [SAMPLE_WIDTH-1:0]    sample_share0,
  input  logic [SAMPLE_WIDTH-1:0]    sample_share1,
  input  logic                       sample_valid,
  output logic [SAMPLE_WIDTH-1:0]    out_share0,
  output logic [SAMPLE_WIDTH-1:0]    out_share1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       done,
  output logic                       timeout_err,
  output logic                       busy,
  output logic [2:0]                 dbg_state_o
);

  localparam int CNT_W = $clog2(RESEED_INTERVAL + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]       INTERVAL = CNT_W'(RESEED_INTERVAL);
  localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0]       TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]       TMO_ONE  = TMO_W'(1);
  localparam logic [COUNT_WIDTH-1:0] REM_ONE  = COUNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_RESEED         = 3'd1,
    S_RESEED_WAIT_HI = 3'd2,
    S_RESEED_WAIT_LO = 3'd3,
    S_ISSUE          = 3'd4,
    S_WAIT_SAMPLE    = 3'd5,
    S_OUTPUT         = 3'd6
  } state_t;

  state_t                     state_q;
  logic                       reseed_pending_q;
  logic [CNT_W-1:0]           smp_cnt_q;
  logic [COUNT_WIDTH-1:0]     remaining_q;
  logic [TMO_W-1:0]           tmo_q;
  logic [CENTER_WIDTH-1:0]    center_q;
  logic [SIGMA_SEL_WIDTH-1:0] sigma_sel_q;
  logic [SAMPLE_WIDTH-1:0]    share0_q;
  logic [SAMPLE_WIDTH-1:0]    share1_q;
  logic                       out_valid_q;
  logic                       out_last_q;
  logic                       start_reseed_q;
  logic                       start_sample_q;
  logic                       done_q;
  logic                       timeout_err_q;

  logic [CNT_W-1:0]       smp_cnt_d;
  logic [COUNT_WIDTH-1:0] remaining_d;
  logic                   in_wait;
  logic                   wait_event;
  logic                   tmo_fire;

  // Next values of the sample budget (saturating) and the batch countdown.
  always_comb begin
    smp_cnt_d   = (smp_cnt_q < INTERVAL) ? smp_cnt_q + CNT_ONE : smp_cnt_q;
    remaining_d = remaining_q - REM_ONE;
  end

  // Which states are bounded waits and what ends each wait.
  always_comb begin
    in_wait    = 1'b0;
    wait_event = 1'b0;
    case (state_q)
      S_RESEED_WAIT_HI: begin in_wait = 1'b1; wait_event = reseeding;    end
      S_RESEED_WAIT_LO: begin in_wait = 1'b1; wait_event = !reseeding;   end
      S_WAIT_SAMPLE:    begin in_wait = 1'b1; wait_event = sample_valid; end
      default:          begin in_wait = 1'b0; wait_event = 1'b0;         end
    endcase
    // The awaited event on the last allowed cycle still counts as success.
    tmo_fire = in_wait && !wait_event && (tmo_q == TMO_LAST);
  end

  // Batch sequencer: state, datapath registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      reseed_pending_q <= 1'b1;
      smp_cnt_q        <= '0;
      remaining_q      <= '0;
      tmo_q            <= '0;
      center_q         <= '0;
      sigma_sel_q      <= '0;
      share0_q         <= '0;
      share1_q         <= '0;
      out_valid_q      <= 1'b0;
      out_last_q       <= 1'b0;
      start_reseed_q   <= 1'b0;
      start_sample_q   <= 1'b0;
      done_q           <= 1'b0;
      timeout_err_q    <= 1'b0;
    end else begin
      // Pulses last one cycle; the wait counter restarts on every state entry.
      start_reseed_q <= 1'b0;
      start_sample_q <= 1'b0;
      done_q         <= 1'b0;
      tmo_q          <= '0;
      if (abort && state_q != S_IDLE) begin
        // Abort beats everything, including an output handshake.
        state_q          <= S_IDLE;
        out_valid_q      <= 1'b0;
        out_last_q       <= 1'b0;
        reseed_pending_q <= 1'b1;
      end else if (tmo_fire) begin
        state_q          <= S_IDLE;
        out_valid_q      <= 1'b0;
        out_last_q       <= 1'b0;
        reseed_pending_q <= 1'b1;
        timeout_err_q    <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req_valid) begin
              center_q      <= req_center;
              sigma_sel_q   <= req_sigma_sel;
              remaining_q   <= req_count;
              timeout_err_q <= 1'b0;
              if (req_count == '0) begin
                done_q <= 1'b1;
              end else if (reseed_pending_q || smp_cnt_q >= INTERVAL) begin
                state_q        <= S_RESEED;
                start_reseed_q <= 1'b1;
              end else begin
                state_q        <= S_ISSUE;
                start_sample_q <= 1'b1;
              end
            end
          end
          S_RESEED: state_q <= S_RESEED_WAIT_HI;
          S_RESEED_WAIT_HI: begin
            if (reseeding) state_q <= S_RESEED_WAIT_LO;
            else           tmo_q   <= tmo_q + TMO_ONE;
          end
          S_RESEED_WAIT_LO: begin
            if (!reseeding) begin
              smp_cnt_q        <= '0;
              reseed_pending_q <= 1'b0;
              state_q          <= S_ISSUE;
              start_sample_q   <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TMO_ONE;
            end
          end
          S_ISSUE: state_q <= S_WAIT_SAMPLE;
          S_WAIT_SAMPLE: begin
            if (sample_valid) begin
              share0_q    <= sample_share0;
              share1_q    <= sample_share1;
              out_valid_q <= 1'b1;
              out_last_q  <= (remaining_d == '0);
              smp_cnt_q   <= smp_cnt_d;
              remaining_q <= remaining_d;
              state_q     <= S_OUTPUT;
            end else begin
              tmo_q <= tmo_q + TMO_ONE;
            end
          end
          S_OUTPUT: begin
            // No timeout here: consumer backpressure may last indefinitely.
            if (out_ready) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              if (remaining_q == '0) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else if (smp_cnt_q >= INTERVAL) begin
                state_q        <= S_RESEED;
                start_reseed_q <= 1'b1;
              end else begin
                state_q        <= S_ISSUE;
                start_sample_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign start_reseed = start_reseed_q;
  assign start_sample = start_sample_q;
  assign center       = center_q;
  assign sigma_sel    = sigma_sel_q;
  assign out_share0   = share0_q;
  assign out_share1   = share1_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign done         = done_q;
  assign timeout_err  = timeout_err_q;
  assign dbg_state_o  = state_q;

endmodule
